// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one SPI flash between a USB SPI bridge (requester 0)
// and a boot-header reader (requester 1). Ownership is granted with round-robin
// tie-break, held until the owner drops req with CS high, and followed by a
// forced CS-high guard gap before the next owner.
// Optional SCK-idle watchdog: define SPI_ARB_WDOG_EN.
module spi_flash_arbiter #(
  parameter int          GUARD_CYCLES = 4,
  parameter logic [15:0] WDOG_CYCLES  = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic cs_b0,
  input  logic sck0,
  input  logic mosi0,
  input  logic cs_b1,
  input  logic sck1,
  input  logic mosi1,
  output logic miso0,
  output logic miso1,
  output logic spi_cs_b,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic wdog_event
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_e;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_e     state_q, state_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [7:0] guard_q, guard_d;
  logic       last_q, last_d;   // most recent owner; reset to 1 so requester 0 wins first tie
  logic       elig0, elig1;
  logic       fire0, fire1;

`ifdef SPI_ARB_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  mask_q, mask_d;
  logic        sck0_prev_q, sck1_prev_q;
  logic        wdog_event_q;
  logic        own_sck, own_prev;

  // Watchdog: count owner cycles with SCK unchanged, mask a requester it evicts
  always_comb begin
    own_sck  = (state_q == OWN1) ? sck1 : sck0;
    own_prev = (state_q == OWN1) ? sck1_prev_q : sck0_prev_q;
    wdog_d   = '0;
    if (state_q == OWN0 || state_q == OWN1)
      wdog_d = (own_sck != own_prev) ? 16'd0 : wdog_q + 16'd1;
    fire0  = (state_q == OWN0) && (wdog_d == WDOG_CYCLES);
    fire1  = (state_q == OWN1) && (wdog_d == WDOG_CYCLES);
    elig0  = req0 & ~mask_q[0];
    elig1  = req1 & ~mask_q[1];
    mask_d = mask_q;
    if (!req0) mask_d[0] = 1'b0;
    if (!req1) mask_d[1] = 1'b0;
    if (fire0) mask_d[0] = 1'b1;
    if (fire1) mask_d[1] = 1'b1;
  end

  // Watchdog state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q       <= '0;
      mask_q       <= '0;
      sck0_prev_q  <= 1'b0;
      sck1_prev_q  <= 1'b0;
      wdog_event_q <= 1'b0;
    end else begin
      wdog_q       <= wdog_d;
      mask_q       <= mask_d;
      sck0_prev_q  <= sck0;
      sck1_prev_q  <= sck1;
      wdog_event_q <= fire0 | fire1;
    end
  end

  assign wdog_event = wdog_event_q;
`else
  assign elig0 = req0;
  assign elig1 = req1;
  assign fire0 = 1'b0;
  assign fire1 = 1'b0;
  // Always 0; the parameter is referenced only so both builds share one interface
  assign wdog_event = 1'b0 & (|WDOG_CYCLES);
`endif

  // Next-state: arbitration in IDLE, release on req low with CS high, guard countdown
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (elig0 && elig1) state_d = last_q ? OWN0 : OWN1;
        else if (elig0)     state_d = OWN0;
        else if (elig1)     state_d = OWN1;
      end
      OWN0: begin
        if (fire0 || (!req0 && cs_b0)) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (fire1 || (!req1 && cs_b1)) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
          last_d  = 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == 8'd0) state_d = IDLE;
        else                 guard_d = guard_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      guard_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      guard_q <= guard_d;
      last_q  <= last_d;
    end
  end

  // Pin mux: owner drives the flash, everyone else sees CS high and MISO 0
  always_comb begin
    spi_cs_b = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    miso0    = 1'b0;
    miso1    = 1'b0;
    case (state_q)
      OWN0: begin
        spi_cs_b = cs_b0;
        spi_sck  = sck0;
        spi_mosi = mosi0;
        miso0    = spi_miso;
      end
      OWN1: begin
        spi_cs_b = cs_b1;
        spi_sck  = sck1;
        spi_mosi = mosi1;
        miso1    = spi_miso;
      end
      default: ;
    endcase
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Testbench for spi_flash_arbiter: directed scenarios followed by randomized
// traffic checked against a cycle-level behavioural model.
module tb_spi_flash_arbiter;

  localparam int          G  = 4;
  localparam logic [15:0] WD = 16'd20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 0, req1 = 0;
  logic cs_b0 = 1, sck0 = 0, mosi0 = 0;
  logic cs_b1 = 1, sck1 = 0, mosi1 = 0;
  logic spi_miso = 0;
  logic gnt0, gnt1, miso0, miso1, spi_cs_b, spi_sck, spi_mosi, busy, wdog_event;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.GUARD_CYCLES(G), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .cs_b0(cs_b0), .sck0(sck0), .mosi0(mosi0),
    .cs_b1(cs_b1), .sck1(sck1), .mosi1(mosi1),
    .miso0(miso0), .miso1(miso1),
    .spi_cs_b(spi_cs_b), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .busy(busy), .wdog_event(wdog_event)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pins_quiet();
    req0 = 0; req1 = 0;
    cs_b0 = 1; sck0 = 0; mosi0 = 0;
    cs_b1 = 1; sck1 = 0; mosi1 = 0;
    spi_miso = 0;
  endtask

  task automatic do_reset();
    pins_quiet();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Behavioural model: who owns the bus, how much guard time remains
  int       m_owner;   // -1 none, else requester index
  int       m_guard;   // guard cycles still to spend
  int       m_run;     // consecutive owner cycles with SCK unchanged
  bit       m_last;
  bit [1:0] m_mask;
  bit       m_prev0, m_prev1, m_wev;

  task automatic model_reset();
    m_owner = -1; m_guard = 0; m_run = 0; m_last = 1;
    m_mask = 0; m_prev0 = 0; m_prev1 = 0; m_wev = 0;
  endtask

  task automatic model_step();
    bit       fire, rq, cb, s, p, e0, e1;
    bit [1:0] old_mask;
    fire = 0;
    old_mask = m_mask;
    e0 = req0 && !old_mask[0];
    e1 = req1 && !old_mask[1];
    if (m_owner >= 0) begin
      s  = (m_owner == 1) ? sck1 : sck0;
      p  = (m_owner == 1) ? m_prev1 : m_prev0;
      rq = (m_owner == 1) ? req1 : req0;
      cb = (m_owner == 1) ? cs_b1 : cs_b0;
      m_run = (s != p) ? 0 : m_run + 1;
`ifdef SPI_ARB_WDOG_EN
      fire = (m_run == int'(WD));
`endif
      if (fire || (!rq && cb)) begin
        m_last  = (m_owner == 1);
        if (fire) m_mask[m_owner] = 1'b1;
        m_owner = -1;
        m_guard = G;
        m_run   = 0;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else begin
      m_run = 0;
      if (e0 && e1) m_owner = m_last ? 0 : 1;
      else if (e0)  m_owner = 0;
      else if (e1)  m_owner = 1;
    end
    if (!req0 && !(fire && m_owner == -1 && m_last == 0)) m_mask[0] = 1'b0;
    if (!req1 && !(fire && m_owner == -1 && m_last == 1)) m_mask[1] = 1'b0;
    m_prev0 = sck0;
    m_prev1 = sck1;
    m_wev   = fire;
  endtask

  initial begin
    // Reset state
    pins_quiet();
    reset = 1;
    tick(); tick();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", spi_cs_b, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_wdog", wdog_event, 0);
    reset = 0;

    // Single request, pin routing, release and guard length
    req0 = 1; tick();
    chk("single_gnt0", gnt0, 1);
    chk("single_gnt1", gnt1, 0);
    chk("single_busy", busy, 1);
    cs_b0 = 0; sck0 = 1; mosi0 = 1; spi_miso = 1; #1;
    chk("single_cs", spi_cs_b, 0);
    chk("single_sck", spi_sck, 1);
    chk("single_mosi", spi_mosi, 1);
    chk("single_miso0", miso0, 1);
    chk("single_miso1", miso1, 0);
    req0 = 0; cs_b0 = 1; sck0 = 0; mosi0 = 0; tick();
    chk("rel_gnt0", gnt0, 0);
    chk("rel_cs", spi_cs_b, 1);
    chk("rel_busy", busy, 1);
    for (int i = 1; i < G; i++) begin
      tick();
      chk("guard_busy", busy, 1);
      chk("guard_cs", spi_cs_b, 1);
    end
    tick();
    chk("guard_end_busy", busy, 0);

    // Round-robin ties after reset: 0, then 1, then 0
    do_reset();
    req0 = 1; req1 = 1; tick();
    chk("tie1_gnt0", gnt0, 1);
    chk("tie1_gnt1", gnt1, 0);
    req0 = 0; tick();
    chk("tie1_rel", gnt0, 0);
    req0 = 1;
    repeat (G) tick();
    chk("tie2_idle_gnt0", gnt0, 0);
    chk("tie2_idle_gnt1", gnt1, 0);
    chk("tie2_idle_busy", busy, 0);
    tick();
    chk("tie2_gnt1", gnt1, 1);
    chk("tie2_gnt0", gnt0, 0);
    req1 = 0; tick();
    req1 = 1;
    repeat (G) tick();
    tick();
    chk("tie3_gnt0", gnt0, 1);
    chk("tie3_gnt1", gnt1, 0);
    req0 = 0; req1 = 0; tick();
    repeat (G) tick();

    // Held transaction: req dropped while CS low keeps ownership
    req0 = 1; tick();
    chk("hold_gnt", gnt0, 1);
    cs_b0 = 0; req0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_keep", gnt0, 1);
    end
    cs_b0 = 1; tick();
    chk("hold_release", gnt0, 0);
    repeat (G) tick();

    // Isolation: requester 1 activity never reaches the flash while 0 owns it
    req0 = 1; tick();
    cs_b0 = 0;
    for (int i = 0; i < 8; i++) begin
      cs_b1 = 1'($urandom); sck1 = 1'($urandom); mosi1 = 1'($urandom);
      spi_miso = 1'($urandom); sck0 = 1'(i); #1;
      chk("iso_cs", spi_cs_b, cs_b0);
      chk("iso_sck", spi_sck, sck0);
      chk("iso_miso1", miso1, 0);
      chk("iso_miso0", miso0, spi_miso);
      tick();
    end
    pins_quiet(); tick();
    repeat (G) tick();

    // Mid-transaction reset releases immediately; next tie goes to 0
    req1 = 1; tick();
    chk("mrst_gnt1", gnt1, 1);
    cs_b1 = 0; sck1 = 1; #1;
    chk("mrst_cs_own", spi_cs_b, 0);
    reset = 1; tick();
    chk("mrst_cs", spi_cs_b, 1);
    chk("mrst_gnt1_off", gnt1, 0);
    chk("mrst_busy", busy, 0);
    reset = 0; req0 = 1; tick();
    chk("mrst_tie_gnt0", gnt0, 1);
    chk("mrst_tie_gnt1", gnt1, 0);

`ifdef SPI_ARB_WDOG_EN
    // Watchdog: static SCK evicts the owner and masks it until req drops
    do_reset();
    req1 = 1; cs_b1 = 0; tick();
    chk("wd_gnt1", gnt1, 1);
    for (int i = 1; i < int'(WD); i++) begin
      tick();
      chk("wd_hold", gnt1, 1);
      chk("wd_quiet", wdog_event, 0);
    end
    tick();
    chk("wd_event", wdog_event, 1);
    chk("wd_gnt_off", gnt1, 0);
    chk("wd_cs", spi_cs_b, 1);
    tick();
    chk("wd_pulse_end", wdog_event, 0);
    cs_b1 = 1;
    repeat (8) begin
      tick();
      chk("wd_masked", gnt1, 0);
    end
    req1 = 0; tick();
    req1 = 1; tick();
    chk("wd_regrant", gnt1, 1);
`endif

    // Randomized traffic against the behavioural model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      cs_b0 = 1'($urandom); cs_b1 = 1'($urandom);
      if ($urandom_range(0, 15) == 0) sck0 = ~sck0;
      if ($urandom_range(0, 15) == 0) sck1 = ~sck1;
      mosi0 = 1'($urandom); mosi1 = 1'($urandom); spi_miso = 1'($urandom);
      #1;
      chk("rnd_cs", spi_cs_b, (m_owner == 0) ? cs_b0 : (m_owner == 1) ? cs_b1 : 1'b1);
      chk("rnd_sck", spi_sck, (m_owner == 0) ? sck0 : (m_owner == 1) ? sck1 : 1'b0);
      chk("rnd_mosi", spi_mosi, (m_owner == 0) ? mosi0 : (m_owner == 1) ? mosi1 : 1'b0);
      chk("rnd_miso0", miso0, (m_owner == 0) ? spi_miso : 1'b0);
      chk("rnd_miso1", miso1, (m_owner == 1) ? spi_miso : 1'b0);
      model_step();
      tick();
      chk("rnd_gnt0", gnt0, m_owner == 0);
      chk("rnd_gnt1", gnt1, m_owner == 1);
      chk("rnd_busy", busy, (m_owner >= 0) || (m_guard > 0));
      chk("rnd_wdog", wdog_event, m_wev);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
